lc4_div_iter: RTL
=================

# lc4_div_iter

Iterative 16-bit unsigned divider for the LC4 pipeline's DIV/MOD path. It sits directly downstream of the 16-bit carry-lookahead adder (`cla16`) and consumes its sum output as the trial-subtraction datapath. It produces one quotient bit per cycle, so a full divide takes 16 compute cycles. Operands and results move through a valid/ready handshake so the execute stage can stall on it.

## Interface
- `WIDTH`, 16: operand width; only 16 is supported (the adder instance is fixed-width).
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: a new operand pair is present.
- `in_ready` output 1: the block can accept operands; high only in IDLE.
- `dividend` input 16: unsigned dividend, sampled on acceptance.
- `divisor` input 16: unsigned divisor, sampled on acceptance.
- `out_valid` output 1: quotient and remainder are valid; high only in DONE.
- `out_ready` input 1: the consumer accepts the result.
- `quotient` output 16: floor(dividend/divisor), or 0 when divisor = 0.
- `remainder` output 16: dividend mod divisor, or 0 when divisor = 0.

## Operation
- **Acceptance.** An operand pair is accepted on a rising edge where `in_valid & in_ready`. `in_valid` is ignored in RUN and DONE.
- **State machine.** The states are IDLE, RUN and DONE, with a 4-bit iteration counter `cnt`.
  - IDLE, operands accepted, divisor ≠ 0: go to RUN. Load `rem`=0, `quo`=dividend, `div`=divisor, `cnt`=0.
  - IDLE, operands accepted, divisor = 0: go directly to DONE. `quotient`=0, `remainder`=0.
  - RUN, `cnt`=15: go to DONE. Otherwise `cnt` increments.
  - DONE, `out_ready`=1: go to IDLE. `quotient` and `remainder` hold their values until the next acceptance.
- **Per-iteration arithmetic (restoring division).**
  - `sh` = {`rem`[14:0], `quo`[15]}.
  - `diff` = `cla16`(a=`sh`, b=~`div`, cin=1), which gives `sh` − `div` mod 2^16.
  - The adder has no carry-out, so rebuild it: `c15` = `diff`[15] ^ `sh`[15] ^ ~`div`[15]; `cout` = maj(`sh`[15], ~`div`[15], `c15`).
  - `ge` = `rem`[15] | `cout`. When `rem`[15]=1, the true 17-bit shifted value is ≥ 2^16 > `div`, so the subtraction always succeeds and the wrapped `diff` is exact.
  - `rem` ← `ge` ? `diff` : `sh`.
  - `quo` ← {`quo`[14:0], `ge`}.
- **Results.** In DONE, `quotient` = `quo` and `remainder` = `rem`.
- **Structure.** Exactly one `cla16` instance is shared across all iterations. There is no `*`, `/` or `%`, and no separate subtractor.
- **Reset.** Reset forces IDLE with `in_ready`=1 (while `rst_n` is deasserted), `out_valid`=0, `quotient`=0, `remainder`=0 and all internal registers 0. This also applies mid-RUN or in DONE: any in-flight operation is discarded and no result is produced.

## Timing
- **Nonzero divisor.** Operands accepted at edge k. RUN occupies cycles k..k+15. DONE is entered at edge k+16, so `out_valid` is high in the cycle after edge k+16: 16-cycle latency.
- **Zero divisor.** DONE is entered at edge k, so `out_valid` is high in the cycle after edge k: 1-cycle latency, no RUN.
- **Handshake.**
  - `in_ready` falls in the cycle after acceptance.
  - `out_valid` stays high, with results stable, until an edge with `out_ready`=1. The block then returns to IDLE.
  - With `out_ready` tied high, back-to-back divides have an issue interval of 18 cycles (acceptance, 16 RUN, 1 DONE).
  - A new divide cannot be accepted in the same cycle a result is drained; IDLE is required first.
- **Reset timing.** `rst_n` low takes effect immediately, independent of `clk`. Release is synchronous: the first state change occurs on the first rising edge with `rst_n` high.
- **Outputs.** `quotient` and `remainder` come directly from registers; there is no combinational path from inputs to outputs. `in_ready` and `out_valid` are decoded from the state register only.

## Test plan
- **Basic divide.** Reset, then accept 100/7 → `out_valid` exactly 16 cycles after acceptance with q=14, r=2. `in_ready`=0 throughout RUN/DONE.
- **Wrapped-subtraction path.** 0xFFFF/1 → q=0xFFFF, r=0. 0xFFFF/0x8000 → q=1, r=0x7FFF. 0xFFFE/0xFFFF → q=0, r=0xFFFE. These exercise the `rem`[15] case and the rebuilt carry-out.
- **Divide by zero.** 1234/0 → `out_valid` in the cycle after acceptance with q=0, r=0. A following 9/3 then yields q=3, r=0.
- **Backpressure.** Run 50/6 with `out_ready` low for 5 cycles after `out_valid`. q=8, r=2 must stay stable and `in_ready` must stay 0; a pulse on `in_valid` during this window is ignored. Then raise `out_ready` → IDLE next cycle.
- **Reset mid-operation.** Assert `rst_n`=0 asynchronously after the 8th RUN cycle of 0x1234/0x0011. The outputs must go immediately to `out_valid`=0, q=0, r=0, and `in_ready` must be 1 while `rst_n` is low. After release, a new 0x1234/0x0011 gives q=0x0112, r=0x0002.
- **Random check.** 10,000 random operand pairs, 5% of them with divisor 0, compared against a reference model. The check also asserts the 16- or 1-cycle latency exactly.

Source files
------------

// File: rtl/lc4_div_iter.sv
// Iterative 16-bit unsigned restoring divider for the LC4 DIV/MOD path.
// One quotient bit per cycle through a shared carry-lookahead adder, valid/ready on both sides.

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);
  logic [15:0] p, g, c;
  logic [3:0]  gp, gg, gc;

  assign p = a ^ b;
  assign g = a & b;

  // Group carries resolved in one lookahead level from 4-bit group P/G.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
                 (gp[2] & gp[1] & gp[0] & cin);

  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;
    assign gp[k] = &p[B +: 4];
    assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1]) |
                   (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign c[B]   = gc[k];
    assign c[B+1] = g[B] | (p[B] & gc[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B]) |
                    (p[B+2] & p[B+1] & p[B] & gc[k]);
  end

  assign sum = p ^ c;
endmodule

module lc4_div_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] rem, quo, div;
  logic [15:0] sh, ndiv, diff;
  logic        c15, cout, ge;

  assign sh   = {rem[14:0], quo[15]};
  assign ndiv = ~div;

  cla16 u_cla (.a(sh), .b(ndiv), .cin(1'b1), .sum(diff));

  // The adder exposes no carry-out; recover the bit-15 carry-in from the sum, then take the majority.
  assign c15  = diff[15] ^ sh[15] ^ ndiv[15];
  assign cout = (sh[15] & ndiv[15]) | (sh[15] & c15) | (ndiv[15] & c15);
  // A set rem[15] means the shifted value is a 17-bit number, which always exceeds div.
  assign ge   = rem[15] | cout;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      div   <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          cnt <= '0;
          rem <= '0;
          if (divisor != '0) begin
            state <= S_RUN;
            quo   <= dividend;
            div   <= divisor;
          end else begin
            state <= S_DONE;
            quo   <= '0;
            div   <= '0;
          end
        end
        S_RUN: begin
          rem <= ge ? diff : sh;
          quo <= {quo[14:0], ge};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
